// File: rtl/vc_pop_arbiter_if.sv
// Pop/arbitration bundle between the VC FIFOs, the destination FIFOs and the arbiter.
// The master side is the arbiter: it samples the full/empty flags and drives pops and status.
`timescale 1ns/1ps
interface vc_pop_arbiter_if #(
    parameter int NUM_VC = 2,
    parameter int NUM_D  = 2
);
    localparam int SEL_W = $clog2(NUM_VC);

    logic [NUM_D-1:0]  D_full;
    logic [NUM_VC-1:0] VC_empty;
    logic [NUM_VC-1:0] VC_rd;
    logic              pop_valid;
    logic [SEL_W-1:0]  vc_sel;
    logic              vc_delay;
    logic              starve_grant;

    modport master (
        input  D_full,
        input  VC_empty,
        output VC_rd,
        output pop_valid,
        output vc_sel,
        output vc_delay,
        output starve_grant
    );

    modport slave (
        output D_full,
        output VC_empty,
        input  VC_rd,
        input  pop_valid,
        input  vc_sel,
        input  vc_delay,
        input  starve_grant
    );
endinterface

// File: rtl/vc_pop_arbiter.sv
// Pops one virtual-channel FIFO per cycle toward the destination FIFOs, using either
// strict priority with starvation override or weighted round robin.
`timescale 1ns/1ps
module vc_pop_arbiter #(
    parameter int NUM_VC       = 2,
    parameter int NUM_D        = 2,
    parameter int MODE         = 0,
    parameter int WEIGHT       = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic             clk,
    input  logic             reset,
    vc_pop_arbiter_if.master bus
);

    localparam int                SEL_W    = $clog2(NUM_VC);
    localparam int                CNT_W    = 8;
    localparam logic [CNT_W-1:0]  LIMIT    = CNT_W'(STARVE_LIMIT);
    localparam logic [4:0]        WEIGHT_C = 5'(WEIGHT);
    localparam logic [NUM_D-1:0]  ALL_FULL = '1;

    logic             stall;

    logic             s_vld;
    logic [SEL_W-1:0] s_idx;
    logic             s_starve;

    logic             w_vld;
    logic             w_scan;
    logic [SEL_W-1:0] w_idx;

    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_starve;

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_nxt;
    logic [3:0]       credit;
    logic [3:0]       credit_nxt;

    // Entry 0 does not exist: VC0 is the highest priority and can never starve.
    logic [CNT_W-1:0] starve_cnt [1:NUM_VC-1];

    function automatic logic [SEL_W-1:0] next_vc(input logic [SEL_W-1:0] idx);
        return (idx == SEL_W'(NUM_VC - 1)) ? '0 : idx + 1'b1;
    endfunction

    // Every destination full means nothing can be accepted; partial fullness does not stall.
    assign stall = (bus.D_full == ALL_FULL);

    always_comb begin : strict_select
        // NOTE: every output gets a default before any branch, so no path can infer a latch.
        s_vld    = 1'b0;
        s_idx    = '0;
        s_starve = 1'b0;
        // Descending scans let the lowest qualifying index win.
        for (int i = NUM_VC - 1; i >= 0; i--) begin
            if (!bus.VC_empty[i]) begin
                s_vld = 1'b1;
                s_idx = SEL_W'(i);
            end
        end
        if (STARVE_LIMIT > 0) begin
            for (int i = NUM_VC - 1; i >= 1; i--) begin
                if (!bus.VC_empty[i] && starve_cnt[i] == LIMIT) begin
                    s_idx    = SEL_W'(i);
                    s_starve = 1'b1;
                end
            end
        end
    end

    always_comb begin : wrr_select
        int cand;
        cand       = 0;
        w_vld      = 1'b0;
        w_scan     = 1'b0;
        w_idx      = ptr;
        ptr_nxt    = ptr;
        credit_nxt = credit;

        if (!bus.VC_empty[ptr]) begin
            w_vld = 1'b1;
        end else begin
            // Circular search from ptr+1; the nearest non-empty VC wins.
            for (int k = NUM_VC - 1; k >= 1; k--) begin
                cand = int'(ptr) + k;
                if (cand >= NUM_VC) cand = cand - NUM_VC;
                if (!bus.VC_empty[SEL_W'(cand)]) begin
                    w_vld  = 1'b1;
                    w_scan = 1'b1;
                    w_idx  = SEL_W'(cand);
                end
            end
        end

        if (w_vld) begin
            if (!w_scan) begin
                if ({1'b0, credit} + 5'd1 == WEIGHT_C) begin
                    ptr_nxt    = next_vc(ptr);
                    credit_nxt = '0;
                end else begin
                    credit_nxt = credit + 4'd1;
                end
            end else if (WEIGHT == 1) begin
                ptr_nxt    = next_vc(w_idx);
                credit_nxt = '0;
            end else begin
                // The jump itself consumes the first pop of the new VC's turn.
                ptr_nxt    = w_idx;
                credit_nxt = 4'd1;
            end
        end
    end

    always_comb begin : grant_mux
        grant_vld    = 1'b0;
        grant_idx    = '0;
        grant_starve = 1'b0;
        if (!reset && !stall) begin
            if (MODE == 1) begin
                grant_vld = w_vld;
                grant_idx = w_idx;
            end else begin
                grant_vld    = s_vld;
                grant_idx    = s_idx;
                grant_starve = s_starve;
            end
        end

        bus.VC_rd = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            bus.VC_rd[i] = grant_vld && (grant_idx == SEL_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            bus.pop_valid    <= 1'b0;
            bus.vc_sel       <= '0;
            bus.vc_delay     <= 1'b0;
            bus.starve_grant <= 1'b0;
            ptr              <= '0;
            credit           <= '0;
            // NOTE: the counter array is reset explicitly because its values steer grants directly.
            for (int i = 1; i < NUM_VC; i++) begin
                starve_cnt[i] <= '0;
            end
        end else begin
            bus.pop_valid    <= grant_vld;
            bus.vc_sel       <= grant_vld ? grant_idx : '0;
            bus.vc_delay     <= grant_vld && (grant_idx != '0);
            bus.starve_grant <= grant_vld && grant_starve;

            if (!stall) begin
                if (MODE == 1) begin
                    ptr    <= ptr_nxt;
                    credit <= credit_nxt;
                end else begin
                    for (int i = 1; i < NUM_VC; i++) begin
                        if (bus.VC_empty[i]) begin
                            starve_cnt[i] <= '0;
                        end else if (grant_vld && grant_idx == SEL_W'(i)) begin
                            starve_cnt[i] <= '0;
                        end else if (starve_cnt[i] != LIMIT) begin
                            starve_cnt[i] <= starve_cnt[i] + 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Bench for vc_pop_arbiter: directed scenarios on several configurations, then a long
// randomized run compared against a behavioural model of the grant rules.
`timescale 1ns/1ps
module tb_vc_pop_arbiter;

    localparam int NDUT = 5;
    localparam int NVC  [NDUT] = '{2, 4, 3, 5, 8};
    localparam int ND   [NDUT] = '{2, 3, 2, 1, 8};
    localparam int MODEP[NDUT] = '{0, 0, 1, 1, 1};
    localparam int WT   [NDUT] = '{4, 4, 2, 1, 3};
    localparam int LIM  [NDUT] = '{0, 3, 16, 16, 16};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NDUT-1:0] rst;
    logic [7:0]      empty_drv [NDUT];
    logic [7:0]      full_drv  [NDUT];
    logic [7:0]      rd_obs    [NDUT];
    logic [2:0]      sel_obs   [NDUT];
    logic [NDUT-1:0] pv_obs;
    logic [NDUT-1:0] dly_obs;
    logic [NDUT-1:0] sg_obs;

    int n_cmp = 0;
    int n_err = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        vc_pop_arbiter_if #(.NUM_VC(NVC[g]), .NUM_D(ND[g])) bus ();
        vc_pop_arbiter #(
            .NUM_VC(NVC[g]), .NUM_D(ND[g]), .MODE(MODEP[g]),
            .WEIGHT(WT[g]), .STARVE_LIMIT(LIM[g])
        ) dut (
            .clk   (clk),
            .reset (rst[g]),
            .bus   (bus)
        );
        assign bus.VC_empty = empty_drv[g][NVC[g]-1:0];
        assign bus.D_full   = full_drv[g][ND[g]-1:0];
        assign rd_obs[g]    = 8'(bus.VC_rd);
        assign sel_obs[g]   = 3'(bus.vc_sel);
        assign pv_obs[g]    = bus.pop_valid;
        assign dly_obs[g]   = bus.vc_delay;
        assign sg_obs[g]    = bus.starve_grant;
    end

    // Behavioural reference state
    int m_ptr    [NDUT];
    int m_credit [NDUT];
    int m_cnt    [NDUT][8];
    bit exp_pv   [NDUT];
    bit exp_dly  [NDUT];
    bit exp_sg   [NDUT];
    int exp_sel  [NDUT];

    function automatic logic [7:0] onehot(input int g);
        return (g < 0) ? 8'h00 : 8'(1 << g);
    endfunction

    function automatic bit is_stall(input int d);
        int mask;
        mask = (1 << ND[d]) - 1;
        return (int'(full_drv[d]) & mask) == mask;
    endfunction

    function automatic void model_eval(input int d, output int g, output bit sv);
        int n;
        n  = NVC[d];
        g  = -1;
        sv = 1'b0;
        if (rst[d] || is_stall(d)) return;
        if (MODEP[d] == 0) begin
            if (LIM[d] > 0) begin
                for (int i = 1; i < n; i++) begin
                    if (!empty_drv[d][i] && m_cnt[d][i] == LIM[d]) begin
                        g = i; sv = 1'b1; return;
                    end
                end
            end
            for (int i = 0; i < n; i++) begin
                if (!empty_drv[d][i]) begin g = i; return; end
            end
        end else begin
            for (int k = 0; k < n; k++) begin
                if (!empty_drv[d][(m_ptr[d] + k) % n]) begin
                    g = (m_ptr[d] + k) % n; return;
                end
            end
        end
    endfunction

    function automatic void model_commit(input int d, input int g, input bit sv);
        int n;
        n          = NVC[d];
        exp_pv[d]  = (g >= 0);
        exp_sel[d] = (g >= 0) ? g : 0;
        exp_dly[d] = (g > 0);
        exp_sg[d]  = sv;
        if (rst[d]) begin
            m_ptr[d] = 0; m_credit[d] = 0;
            for (int i = 0; i < 8; i++) m_cnt[d][i] = 0;
            exp_pv[d] = 0; exp_sel[d] = 0; exp_dly[d] = 0; exp_sg[d] = 0;
            return;
        end
        if (is_stall(d)) return;
        if (MODEP[d] == 0) begin
            for (int i = 1; i < n; i++) begin
                if (empty_drv[d][i] || g == i) m_cnt[d][i] = 0;
                else if (m_cnt[d][i] < LIM[d]) m_cnt[d][i]++;
            end
        end else if (g >= 0) begin
            if (g == m_ptr[d]) begin
                m_credit[d]++;
            end else begin
                m_ptr[d] = g; m_credit[d] = 1;
            end
            if (m_credit[d] == WT[d]) begin
                m_ptr[d] = (m_ptr[d] + 1) % n; m_credit[d] = 0;
            end
        end
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = '1;
        for (int d = 0; d < NDUT; d++) begin
            empty_drv[d] = 8'h00;
            full_drv[d]  = 8'h00;
        end
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            n_cmp++;
            if (rd_obs[d] !== 8'h00) begin
                n_err++;
                $display("FAIL reset_rd dut%0d: got %h want 00", d, rd_obs[d]);
            end
        end
        next_cycle();
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            n_cmp++;
            if ({pv_obs[d], dly_obs[d], sg_obs[d], sel_obs[d]} !== 6'b0) begin
                n_err++;
                $display("FAIL reset_regs dut%0d: got pv=%b dly=%b sg=%b sel=%0d want all 0",
                         d, pv_obs[d], dly_obs[d], sg_obs[d], sel_obs[d]);
            end
        end
        next_cycle();
    endtask

    task automatic test_strict_basic();
        rst[0] = 1'b0; empty_drv[0] = 8'h00; full_drv[0] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (rd_obs[0] !== 8'h01) begin
                n_err++; $display("FAIL strict_vc0 cyc%0d: got %h want 01", i, rd_obs[0]);
            end
            if (i > 0) begin
                n_cmp++;
                if ({pv_obs[0], sel_obs[0], dly_obs[0]} !== {1'b1, 3'd0, 1'b0}) begin
                    n_err++;
                    $display("FAIL strict_vc0_regs cyc%0d: got pv=%b sel=%0d dly=%b want 1/0/0",
                             i, pv_obs[0], sel_obs[0], dly_obs[0]);
                end
            end
            next_cycle();
        end
        empty_drv[0] = 8'h01;
        @(negedge clk);
        n_cmp++;
        if (rd_obs[0] !== 8'h02) begin
            n_err++; $display("FAIL strict_vc1: got %h want 02", rd_obs[0]);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if ({pv_obs[0], sel_obs[0], dly_obs[0]} !== {1'b1, 3'd1, 1'b1}) begin
            n_err++;
            $display("FAIL strict_vc1_regs: got pv=%b sel=%0d dly=%b want 1/1/1",
                     pv_obs[0], sel_obs[0], dly_obs[0]);
        end
        next_cycle();
        rst[0] = 1'b1;
        next_cycle();
    endtask

    task automatic test_stall();
        rst[0] = 1'b0; empty_drv[0] = 8'h00; full_drv[0] = 8'h03;
        @(negedge clk);
        n_cmp++;
        if (rd_obs[0] !== 8'h00) begin
            n_err++; $display("FAIL stall_rd: got %h want 00", rd_obs[0]);
        end
        next_cycle();
        full_drv[0] = 8'h02;
        @(negedge clk);
        n_cmp++;
        if (rd_obs[0] !== 8'h01 || pv_obs[0] !== 1'b0) begin
            n_err++;
            $display("FAIL stall_resume: got rd=%h pv=%b want rd=01 pv=0", rd_obs[0], pv_obs[0]);
        end
        next_cycle();
        full_drv[0] = 8'h01;
        @(negedge clk);
        n_cmp++;
        if (rd_obs[0] !== 8'h01 || pv_obs[0] !== 1'b1) begin
            n_err++;
            $display("FAIL stall_partial: got rd=%h pv=%b want rd=01 pv=1", rd_obs[0], pv_obs[0]);
        end
        next_cycle();
        rst[0] = 1'b1; full_drv[0] = 8'h00;
        next_cycle();
    endtask

    task automatic test_starvation();
        int g_seq [8] = '{0, 0, 0, 1, 2, 3, 0, 1};
        bit s_seq [8] = '{0, 0, 0, 1, 1, 1, 0, 1};
        int h_seq [7] = '{0, 0, -1, -1, -1, 0, 1};
        rst[1] = 1'b1; next_cycle();
        rst[1] = 1'b0; empty_drv[1] = 8'h00; full_drv[1] = 8'h00;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i < 8) begin
                n_cmp++;
                if (rd_obs[1] !== onehot(g_seq[i])) begin
                    n_err++;
                    $display("FAIL starve_seq cyc%0d: got %h want %h", i, rd_obs[1], onehot(g_seq[i]));
                end
            end
            if (i > 0) begin
                n_cmp++;
                if (sg_obs[1] !== s_seq[i-1] || sel_obs[1] !== 3'(g_seq[i-1])) begin
                    n_err++;
                    $display("FAIL starve_flag cyc%0d: got sg=%b sel=%0d want sg=%b sel=%0d",
                             i, sg_obs[1], sel_obs[1], s_seq[i-1], g_seq[i-1]);
                end
            end
            next_cycle();
        end
        // Counters must hold across a full stall
        rst[1] = 1'b1; next_cycle();
        rst[1] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            full_drv[1] = (h_seq[i] < 0) ? 8'h07 : 8'h00;
            @(negedge clk);
            n_cmp++;
            if (rd_obs[1] !== onehot(h_seq[i])) begin
                n_err++;
                $display("FAIL starve_hold cyc%0d: got %h want %h", i, rd_obs[1], onehot(h_seq[i]));
            end
            next_cycle();
        end
        rst[1] = 1'b1;
        next_cycle();
    endtask

    task automatic test_wrr();
        int a_seq [8] = '{0, 0, 1, 1, 2, 2, 0, 0};
        int b_seq [6] = '{0, 0, 2, 2, 0, 0};
        rst[2] = 1'b1; next_cycle();
        rst[2] = 1'b0; empty_drv[2] = 8'h00; full_drv[2] = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_cmp++;
            if (rd_obs[2] !== onehot(a_seq[i])) begin
                n_err++;
                $display("FAIL wrr_full cyc%0d: got %h want %h", i, rd_obs[2], onehot(a_seq[i]));
            end
            if (i > 0) begin
                n_cmp++;
                if (sel_obs[2] !== 3'(a_seq[i-1]) || dly_obs[2] !== (a_seq[i-1] != 0)) begin
                    n_err++;
                    $display("FAIL wrr_sel cyc%0d: got sel=%0d dly=%b want sel=%0d", i,
                             sel_obs[2], dly_obs[2], a_seq[i-1]);
                end
            end
            next_cycle();
        end
        rst[2] = 1'b1; next_cycle();
        rst[2] = 1'b0; empty_drv[2] = 8'h02;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if (rd_obs[2] !== onehot(b_seq[i])) begin
                n_err++;
                $display("FAIL wrr_skip cyc%0d: got %h want %h", i, rd_obs[2], onehot(b_seq[i]));
            end
            next_cycle();
        end
        rst[2] = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset_midturn();
        int pre  [3] = '{0, 0, 1};
        int post [4] = '{0, 0, 1, 1};
        rst[2] = 1'b1; next_cycle();
        rst[2] = 1'b0; empty_drv[2] = 8'h00; full_drv[2] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (rd_obs[2] !== onehot(pre[i])) begin
                n_err++;
                $display("FAIL midturn_pre cyc%0d: got %h want %h", i, rd_obs[2], onehot(pre[i]));
            end
            next_cycle();
        end
        rst[2] = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rd_obs[2] !== 8'h00) begin
            n_err++; $display("FAIL midturn_rst_rd: got %h want 00", rd_obs[2]);
        end
        next_cycle();
        rst[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin
                n_cmp++;
                if ({pv_obs[2], dly_obs[2], sg_obs[2], sel_obs[2]} !== 6'b0) begin
                    n_err++;
                    $display("FAIL midturn_regs: got pv=%b dly=%b sg=%b sel=%0d want all 0",
                             pv_obs[2], dly_obs[2], sg_obs[2], sel_obs[2]);
                end
            end
            n_cmp++;
            if (rd_obs[2] !== onehot(post[i])) begin
                n_err++;
                $display("FAIL midturn_post cyc%0d: got %h want %h", i, rd_obs[2], onehot(post[i]));
            end
            next_cycle();
        end
        rst[2] = 1'b1;
        next_cycle();
    endtask

    task automatic test_random();
        int g;
        bit sv;
        int r;
        rst = '1;
        next_cycle();
        for (int d = 0; d < NDUT; d++) begin
            m_ptr[d] = 0; m_credit[d] = 0;
            for (int i = 0; i < 8; i++) m_cnt[d][i] = 0;
            exp_pv[d] = 0; exp_sel[d] = 0; exp_dly[d] = 0; exp_sg[d] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            for (int d = 0; d < NDUT; d++) begin
                rst[d] = ($urandom_range(0, 299) == 0);
                r = int'($urandom_range(0, 7));
                if (r == 0)      empty_drv[d] = 8'hff;
                else if (r == 1) empty_drv[d] = 8'h00;
                else             empty_drv[d] = 8'($urandom);
                r = int'($urandom_range(0, 7));
                if (r == 0)      full_drv[d] = 8'hff;
                else if (r < 4)  full_drv[d] = 8'h00;
                else             full_drv[d] = 8'($urandom);
            end
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                model_eval(d, g, sv);
                n_cmp++;
                if ($countones(rd_obs[d]) > 1 || (rd_obs[d] & empty_drv[d]) != 8'h00) begin
                    n_err++;
                    $display("FAIL rand_legal dut%0d cyc%0d: got rd=%h empty=%h want one-hot-or-zero on non-empty",
                             d, c, rd_obs[d], empty_drv[d]);
                end
                n_cmp++;
                if (rd_obs[d] !== onehot(g)) begin
                    n_err++;
                    $display("FAIL rand_grant dut%0d cyc%0d: got %h want %h", d, c, rd_obs[d], onehot(g));
                end
                n_cmp++;
                if (pv_obs[d] !== exp_pv[d] || sel_obs[d] !== 3'(exp_sel[d]) ||
                    dly_obs[d] !== exp_dly[d] || sg_obs[d] !== exp_sg[d]) begin
                    n_err++;
                    $display("FAIL rand_regs dut%0d cyc%0d: got pv=%b sel=%0d dly=%b sg=%b want %b/%0d/%b/%b",
                             d, c, pv_obs[d], sel_obs[d], dly_obs[d], sg_obs[d],
                             exp_pv[d], exp_sel[d], exp_dly[d], exp_sg[d]);
                end
                model_commit(d, g, sv);
            end
            next_cycle();
        end
    endtask

    initial begin
        rst = '1;
        for (int d = 0; d < NDUT; d++) begin
            empty_drv[d] = 8'hff;
            full_drv[d]  = 8'h00;
        end
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_strict_basic();
        test_stall();
        test_starvation();
        test_wrr();
        test_reset_midturn();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
